// File: rtl/noc_pkg.sv
// Shared NoC types and width helpers for the router input port and the link blocks.
// Blocks that take widths as parameters derive them with vc_w()/cnt_w().
package noc_pkg;

    localparam int DEF_D_WIDTH = 16;
    localparam int DEF_DEPTH   = 12;
    localparam int DEF_NUM_VC  = 4;

    function automatic int vc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

    localparam int VW = vc_w(DEF_NUM_VC);
    localparam int CW = cnt_w(DEF_DEPTH);

    typedef logic [DEF_D_WIDTH-1:0] flit_t;
    typedef logic [VW-1:0]          vc_id_t;

endpackage

// File: rtl/vc_fwft_fifo.sv
// Single virtual-channel first-word-fall-through FIFO with occupancy count.
// push/pop arrive already qualified against full/empty by the parent.
module vc_fwft_fifo
    import noc_pkg::*;
#(
    parameter int D_WIDTH  = DEF_D_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = 10,
    parameter int CW       = cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [D_WIDTH-1:0] wr_data,
    output logic [D_WIDTH-1:0] rd_data,
    output logic [CW-1:0]      count,
    output logic               empty,
    output logic               full,
    output logic               afull
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    // Explicit wrap so non-power-of-2 depths never touch unused slots.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign afull   = (count >= CW'(AF_LEVEL));

endmodule

// File: rtl/vc_input_buffer.sv
// Router input-port buffer: NUM_VC FWFT queues behind one write and one read port,
// with a credit pulse per accepted pop and sticky overflow/underflow flags.
module vc_input_buffer
    import noc_pkg::*;
#(
    parameter int D_WIDTH  = DEF_D_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_VC   = DEF_NUM_VC,
    parameter int AF_LEVEL = 10,
    localparam int VW      = vc_w(NUM_VC),
    localparam int CW      = cnt_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [VW-1:0]        wr_vc,
    input  logic [D_WIDTH-1:0]   wr_data,
    input  logic                 rd_en,
    input  logic [VW-1:0]        rd_vc,
    output logic [D_WIDTH-1:0]   rd_data,
    output logic [NUM_VC-1:0]    vc_empty,
    output logic [NUM_VC-1:0]    vc_full,
    output logic [NUM_VC-1:0]    vc_afull,
    output logic [NUM_VC*CW-1:0] vc_count,
    output logic                 credit_valid,
    output logic [VW-1:0]        credit_vc,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    logic [NUM_VC-1:0]  wr_sel;
    logic [NUM_VC-1:0]  rd_sel;
    logic [NUM_VC-1:0]  push;
    logic [NUM_VC-1:0]  pop;
    logic [D_WIDTH-1:0] head [NUM_VC];
    logic               wr_bad;
    logic               rd_bad;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        assign wr_sel[i] = wr_en && (wr_vc == VW'(i));
        assign rd_sel[i] = rd_en && (rd_vc == VW'(i));
        assign push[i]   = wr_sel[i] && !vc_full[i];
        assign pop[i]    = rd_sel[i] && !vc_empty[i];

        vc_fwft_fifo #(
            .D_WIDTH  (D_WIDTH),
            .DEPTH    (DEPTH),
            .AF_LEVEL (AF_LEVEL),
            .CW       (CW)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push[i]),
            .pop     (pop[i]),
            .wr_data (wr_data),
            .rd_data (head[i]),
            .count   (vc_count[i*CW +: CW]),
            .empty   (vc_empty[i]),
            .full    (vc_full[i]),
            .afull   (vc_afull[i])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (rd_vc == VW'(i)) rd_data = head[i];
        end
    end

    // No VC accepts the request when the id is out of range or the target is full/empty.
    assign wr_bad = wr_en && (push == '0);
    assign rd_bad = rd_en && (pop == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_valid  <= 1'b0;
            credit_vc     <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            credit_valid <= |pop;
            credit_vc    <= rd_vc;
            if (wr_bad) overflow_err  <= 1'b1;
            if (rd_bad) underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Randomised and directed checks of vc_input_buffer against a queue-based model.
module tb_vc_input_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 12;
    localparam int NVC   = 4;
    localparam int AFL   = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [1:0]  wr_vc, rd_vc;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic [3:0]  vc_empty, vc_full, vc_afull;
    logic [15:0] vc_count;
    logic        credit_valid;
    logic [1:0]  credit_vc;
    logic        overflow_err, underflow_err;

    logic        wr_en3, rd_en3;
    logic [1:0]  wr_vc3, rd_vc3;
    logic [15:0] wr_data3, rd_data3;
    logic [2:0]  vc_empty3, vc_full3, vc_afull3;
    logic [11:0] vc_count3;
    logic        credit_valid3;
    logic [1:0]  credit_vc3;
    logic        overflow_err3, underflow_err3;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    vc_input_buffer #(.D_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NVC), .AF_LEVEL(AFL)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(rd_data),
        .vc_empty(vc_empty), .vc_full(vc_full), .vc_afull(vc_afull), .vc_count(vc_count),
        .credit_valid(credit_valid), .credit_vc(credit_vc),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    vc_input_buffer #(.D_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(3), .AF_LEVEL(AFL)) u_dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_vc(wr_vc3), .wr_data(wr_data3),
        .rd_en(rd_en3), .rd_vc(rd_vc3), .rd_data(rd_data3),
        .vc_empty(vc_empty3), .vc_full(vc_full3), .vc_afull(vc_afull3), .vc_count(vc_count3),
        .credit_valid(credit_valid3), .credit_vc(credit_vc3),
        .overflow_err(overflow_err3), .underflow_err(underflow_err3)
    );

    // Behavioural model: one queue per VC plus the expected registered outputs.
    typedef logic [15:0] flit_q_t[$];
    flit_q_t q [NVC];
    bit      m_ovf = 0, m_udf = 0, m_cv = 0;
    int      m_cvc = 0;
    bit      m_pop_ok, m_push_ok;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NVC; i++) q[i].delete();
            m_ovf = 0; m_udf = 0; m_cv = 0; m_cvc = 0;
        end else begin
            m_pop_ok  = rd_en && (q[rd_vc].size() != 0);
            m_push_ok = wr_en && (q[wr_vc].size() != DEPTH);
            if (m_pop_ok)  void'(q[rd_vc].pop_front());
            if (m_push_ok) q[wr_vc].push_back(wr_data);
            if (wr_en && !m_push_ok) m_ovf = 1;
            if (rd_en && !m_pop_ok)  m_udf = 1;
            m_cv = m_pop_ok;
            if (m_pop_ok) m_cvc = rd_vc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [3:0]  e_empty, e_full, e_afull;
    logic [15:0] e_cnt;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NVC; i++) begin
                e_empty[i]     = (q[i].size() == 0);
                e_full[i]      = (q[i].size() == DEPTH);
                e_afull[i]     = (q[i].size() >= AFL);
                e_cnt[i*4 +: 4] = 4'(q[i].size());
            end
            chk("m_vc_empty", {28'd0, vc_empty}, {28'd0, e_empty});
            chk("m_vc_full",  {28'd0, vc_full},  {28'd0, e_full});
            chk("m_vc_afull", {28'd0, vc_afull}, {28'd0, e_afull});
            chk("m_vc_count", {16'd0, vc_count}, {16'd0, e_cnt});
            chk("m_credit_valid", {31'd0, credit_valid}, {31'd0, m_cv});
            if (m_cv) chk("m_credit_vc", {30'd0, credit_vc}, 32'(m_cvc));
            chk("m_overflow",  {31'd0, overflow_err},  {31'd0, m_ovf});
            chk("m_underflow", {31'd0, underflow_err}, {31'd0, m_udf});
            if (q[rd_vc].size() != 0) chk("m_rd_data", {16'd0, rd_data}, {16'd0, q[rd_vc][0]});
        end
    end

    task automatic drive(input logic we, input logic [1:0] wv, input logic [15:0] wd,
                         input logic re, input logic [1:0] rv);
        wr_en = we; wr_vc = wv; wr_data = wd; rd_en = re; rd_vc = rv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_drive();
        drive($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), 16'($urandom),
              $urandom_range(0, 99) < 50, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        wr_en3 = 0; wr_vc3 = 0; wr_data3 = 0; rd_en3 = 0; rd_vc3 = 0;
        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;
        chk("reset_empty", {28'd0, vc_empty}, 32'hF);
        chk("reset_count", {16'd0, vc_count}, 32'h0);

        for (int i = 0; i < 60; i++) begin rand_drive(); tick(); end
        rst = 1'b1;
        rand_drive(); tick();
        rand_drive(); tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("midreset_empty",  {28'd0, vc_empty}, 32'hF);
        chk("midreset_count",  {16'd0, vc_count}, 32'h0);
        chk("midreset_credit", {31'd0, credit_valid}, 32'h0);
        chk("midreset_errs",   {30'd0, overflow_err, underflow_err}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            drive(1, 2, 16'h0100 + 16'(i), 0, 0);
            tick();
            if (i == 8) chk("afull_after_9",  {31'd0, vc_afull[2]}, 32'h0);
            if (i == 9) chk("afull_after_10", {31'd0, vc_afull[2]}, 32'h1);
        end
        chk("fill_full",  {28'd0, vc_full}, 32'h4);
        chk("fill_count", {28'd0, vc_count[11:8]}, 32'd12);
        chk("fill_empty", {28'd0, vc_empty}, 32'hB);

        drive(1, 2, 16'hDEAD, 0, 0);
        tick();
        chk("ovf_flag",  {31'd0, overflow_err}, 32'h1);
        chk("ovf_count", {28'd0, vc_count[11:8]}, 32'd12);

        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 1, 2);
            #1;
            chk("pop_data", {16'd0, rd_data}, 32'h0100 + i);
            tick();
            chk("pop_credit",    {31'd0, credit_valid}, 32'h1);
            chk("pop_credit_vc", {30'd0, credit_vc}, 32'h2);
        end
        drive(0, 0, 0, 0, 2);
        tick();
        chk("drain_credit", {31'd0, credit_valid}, 32'h0);
        chk("drain_empty",  {31'd0, vc_empty[2]}, 32'h1);

        for (int i = 0; i < 30; i++) begin
            drive(1, 0, 16'h2000 + 16'(i), 0, 0);
            tick();
            drive(0, 0, 0, 1, 0);
            #1;
            chk("wrap_data", {16'd0, rd_data}, 32'h2000 + i);
            tick();
            chk("wrap_count", {28'd0, vc_count[3:0]}, 32'h0);
        end

        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 16'h3000 + 16'(i), 0, 0);
            tick();
        end
        drive(1, 1, 16'h3005, 1, 1);
        #1;
        chk("same_vc_head", {16'd0, rd_data}, 32'h3000);
        tick();
        chk("same_vc_count", {28'd0, vc_count[7:4]}, 32'd5);
        drive(1, 3, 16'h3100, 1, 1);
        tick();
        chk("diff_vc3_count", {28'd0, vc_count[15:12]}, 32'd1);
        chk("diff_vc1_count", {28'd0, vc_count[7:4]}, 32'd4);
        chk("diff_credit_vc", {30'd0, credit_vc}, 32'h1);
        drive(0, 0, 0, 0, 1);
        #1;
        chk("diff_vc1_head", {16'd0, rd_data}, 32'h3002);

        chk("udf_before",  {31'd0, underflow_err}, 32'h0);
        chk("udf3_before", {31'd0, underflow_err3}, 32'h0);
        drive(0, 0, 0, 1, 0);
        rd_en3 = 1; rd_vc3 = 3;
        tick();
        rd_en3 = 0;
        chk("udf_flag",    {31'd0, underflow_err}, 32'h1);
        chk("udf_credit",  {31'd0, credit_valid}, 32'h0);
        chk("udf_counts",  {16'd0, vc_count}, 32'h1040);
        chk("udf3_flag",   {31'd0, underflow_err3}, 32'h1);
        chk("udf3_credit", {31'd0, credit_valid3}, 32'h0);
        chk("udf3_empty",  {29'd0, vc_empty3}, 32'h7);

        for (int i = 0; i < 800; i++) begin rand_drive(); tick(); end
        drive(0, 0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
